// File: rtl/lbist_tpg.sv
// LBIST pattern generator: Fibonacci LFSR stimulus plus signature address for the ORA.
// Optional LBIST_TPG_DEBRUIJN_EN extends the LFSR to a full de Bruijn cycle including all-zero.
module lbist_tpg #(
    parameter int unsigned         IP_WIDTH     = 4,
    parameter logic [0:IP_WIDTH-1] POLY         = 4'b0011,
    parameter logic [0:IP_WIDTH-1] SEED         = 4'b1000,
    parameter int unsigned         SIG_ADD_BITS = 4,
    parameter int unsigned         PAT_COUNT    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    START,
    input  logic                    HOLD,
    output logic [0:IP_WIDTH-1]     CUT_IP,
    output logic                    PAT_VALID,
    output logic [0:SIG_ADD_BITS-1] IP_SIG_ADD,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned      CNT_W    = $clog2(PAT_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [0:IP_WIDTH-1]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fb_c;
    logic [0:IP_WIDTH-1]  lfsr_step_c;

    // One LFSR step: shift toward the high index, feedback enters at bit 0
    always_comb begin
        fb_c = ^(lfsr_q & POLY);
`ifdef LBIST_TPG_DEBRUIJN_EN
        fb_c = fb_c ^ ~(|lfsr_q[0:IP_WIDTH-2]);
`endif
        lfsr_step_c = {fb_c, lfsr_q[0:IP_WIDTH-2]};
    end

    // Session sequencing
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_RUN;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!HOLD) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        lfsr_d = lfsr_step_c;
                        cnt_d  = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Address is the pattern index, wrapping modulo 2^SIG_ADD_BITS
    assign IP_SIG_ADD = SIG_ADD_BITS'(cnt_q);
    assign CUT_IP     = lfsr_q;
    assign PAT_VALID  = valid_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule
